// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        ARB,
        LOCK
    } arb_state_e;

    typedef logic [31:0] wr_count_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// found by masking the lower copy of a doubled request vector.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] masked;
    logic               found;

    assign dbl = {valid, valid};

    // Lower copy keeps only positions >= ptr; upper copy supplies the wrap-around.
    for (genvar i = 0; i < 2 * N_REQ; i++) begin : g_mask
        if (i < N_REQ) begin : g_lo
            assign masked[i] = dbl[i] & (ptr <= ID_WIDTH'(i));
        end else begin : g_hi
            assign masked[i] = dbl[i];
        end
    end

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (masked[i] && !found) begin
                found     = 1'b1;
                grant_idx = ID_WIDTH'(i % N_REQ);
            end
        end
    end

    for (genvar j = 0; j < N_REQ; j++) begin : g_onehot
        assign grant[j] = found & (grant_idx == ID_WIDTH'(j));
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with a one-entry output stage in front of a shared FIFO.
// Optional burst locking is enabled by defining FIFO_ARB_BURST_LOCK_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]                 req_last,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [DATA_WIDTH-1:0]            fifo_data,
    output logic                             fifo_write_enable,
    input  logic                             fifo_full,
    output logic [ID_WIDTH-1:0]              grant_id,
    output wr_count_t                        wr_count
);

    arb_state_e            state, state_next;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ID_WIDTH-1:0]   out_id;
    logic [ID_WIDTH-1:0]   rr_ptr, ptr_next;
    logic [ID_WIDTH-1:0]   win_id;
    logic [N_REQ-1:0]      cand, grant;
    logic                  can_accept, accept;
`ifdef FIFO_ARB_BURST_LOCK_EN
    logic [ID_WIDTH-1:0]   lock_id, lock_next;
`else
    logic                  unused_ok;
    assign unused_ok = ^req_last;
`endif

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
        return (idx == ID_WIDTH'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign can_accept        = ~out_valid | ~fifo_full;
    assign fifo_write_enable = out_valid & ~fifo_full;
    assign fifo_data         = out_data;
    assign grant_id          = out_id;
    assign req_ready         = (can_accept && !rst) ? grant : '0;
    assign accept            = |req_ready;

    always_comb begin
        cand = req_valid;
`ifdef FIFO_ARB_BURST_LOCK_EN
        if (state == LOCK) begin
            cand          = '0;
            cand[lock_id] = req_valid[lock_id];
        end
`endif
    end

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .valid     (cand),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_id)
    );

    always_comb begin
        state_next = state;
        ptr_next   = rr_ptr;
`ifdef FIFO_ARB_BURST_LOCK_EN
        lock_next  = lock_id;
`endif
        if (accept) begin
            ptr_next = wrap_inc(win_id);
`ifdef FIFO_ARB_BURST_LOCK_EN
            // While locked the winner is always lock_id, so the final word restores lock_id+1.
            case (state)
                ARB: begin
                    if (!req_last[win_id]) begin
                        state_next = LOCK;
                        lock_next  = win_id;
                    end
                end
                LOCK: begin
                    if (req_last[win_id]) state_next = ARB;
                    else                  ptr_next   = rr_ptr;
                end
                default: state_next = ARB;
            endcase
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
`ifdef FIFO_ARB_BURST_LOCK_EN
            lock_id <= '0;
`endif
        end else begin
            state   <= state_next;
`ifdef FIFO_ARB_BURST_LOCK_EN
            lock_id <= lock_next;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
            wr_count  <= '0;
        end else begin
            rr_ptr <= ptr_next;
            if (fifo_write_enable) wr_count <= wr_count + 32'd1;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= req_data[win_id];
                out_id    <= win_id;
            end else if (fifo_write_enable) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter with a word scoreboard on the FIFO side.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 2;

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic [N-1:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } sb_t;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_last;
    logic [N-1:0]         req_ready;
    logic [DW-1:0]        fifo_data;
    logic                 fifo_write_enable;
    logic                 fifo_full;
    logic [IW-1:0]        grant_id;
    wr_count_t            wr_count;

    vec_t        tbl[$];
    sb_t         sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned seq[N];
    logic        m_ov;
    wr_count_t   m_count;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .fifo_data         (fifo_data),
        .fifo_write_enable (fifo_write_enable),
        .fifo_full         (fifo_full),
        .grant_id          (grant_id),
        .wr_count          (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input int unsigned i);
        return {8'(i), 24'h0, seq[i]};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic f, input logic [N-1:0] e);
        tbl.push_back('{r, v, l, f, e});
    endtask

    task automatic apply(input vec_t v, input int unsigned idx);
        logic exp_we;
        sb_t  e;
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        req_last  = v.last;
        fifo_full = v.full;
        for (int unsigned i = 0; i < N; i++) req_data[i] = word_of(i);
        #1;
        exp_we = m_ov & ~v.full;
        chk($sformatf("ready[%0d]", idx), DW'(req_ready), DW'(v.exp_ready));
        chk($sformatf("we[%0d]", idx), DW'(fifo_write_enable), DW'(exp_we));
        chk($sformatf("wr_count[%0d]", idx), DW'(wr_count), DW'(m_count));
        if (exp_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow[%0d]: got write expected none queued", idx);
            end else begin
                e = sb.pop_front();
                chk($sformatf("data[%0d]", idx), fifo_data, e.data);
                chk($sformatf("grant_id[%0d]", idx), DW'(grant_id), DW'(e.id));
            end
            m_count++;
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (v.exp_ready[i]) begin
                sb.push_back('{word_of(i), IW'(i)});
                seq[i]++;
            end
        end
        if (v.rst) begin
            m_ov    = 1'b0;
            m_count = '0;
            sb.delete();
        end else begin
            m_ov = (|v.exp_ready) | (m_ov & v.full);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        fifo_full = 1'b1;
        req_data  = '0;
        m_ov      = 1'b0;
        m_count   = '0;
        for (int unsigned i = 0; i < N; i++) seq[i] = 0;

        // Reset: outputs cleared, no ready even with every requester valid.
        apply('{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000}, 0);
        apply('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000}, 1);
        chk("reset_data", fifo_data, '0);
        chk("reset_grant_id", DW'(grant_id), '0);

        // Single producer: three back-to-back words from req0.
        add(0, 4'b0001, 0, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, 4'b0001);
        add(0, 4'b0001, 0, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 4'b0000);
        // Round-robin from a fresh pointer.
        add(1, 4'b0000, 0, 0, 4'b0000);
        add(0, 4'b1111, 0, 0, 4'b0001);
        add(0, 4'b1111, 0, 0, 4'b0010);
        add(0, 4'b1111, 0, 0, 4'b0100);
        add(0, 4'b1111, 0, 0, 4'b1000);
        add(0, 4'b1111, 0, 0, 4'b0001);
        add(0, 4'b1111, 0, 0, 4'b0010);
        add(0, 4'b0000, 0, 0, 4'b0000);
        // Backpressure: word X from req0 held five cycles, then drain and refill together.
        add(0, 4'b0001, 0, 0, 4'b0001);
        for (int k = 0; k < 5; k++) add(0, 4'b0110, 0, 1, 4'b0000);
        add(0, 4'b0110, 0, 0, 4'b0010);
        add(0, 4'b0100, 0, 0, 4'b0100);
        add(0, 4'b0000, 0, 0, 4'b0000);
        // req2 withdraws while stalled; req3 is served next.
        add(0, 4'b0001, 0, 0, 4'b0001);
        add(0, 4'b0100, 0, 1, 4'b0000);
        add(0, 4'b0000, 0, 1, 4'b0000);
        add(0, 4'b1000, 0, 0, 4'b1000);
        add(0, 4'b0000, 0, 0, 4'b0000);
        // Reset while a word is held under full: word discarded, pointer back to 0.
        add(0, 4'b0010, 0, 0, 4'b0010);
        add(1, 4'b0000, 0, 1, 4'b0000);
        add(0, 4'b1111, 0, 0, 4'b0001);
        add(0, 4'b0000, 0, 0, 4'b0000);
        // Burst from req1 with req0 and req2 competing (pointer now 1).
`ifdef FIFO_ARB_BURST_LOCK_EN
        add(0, 4'b0111, 4'b0000, 0, 4'b0010);
        add(0, 4'b0101, 4'b0000, 0, 4'b0000);
        add(0, 4'b0111, 4'b0000, 0, 4'b0010);
        add(0, 4'b0111, 4'b0010, 0, 4'b0010);
        add(0, 4'b0111, 4'b0000, 0, 4'b0100);
`else
        add(0, 4'b0111, 0, 0, 4'b0010);
        add(0, 4'b0111, 0, 0, 4'b0100);
        add(0, 4'b0111, 0, 0, 4'b0001);
        add(0, 4'b0111, 0, 0, 4'b0010);
`endif
        add(0, 4'b0000, 0, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 4'b0000);

        for (int unsigned i = 0; i < tbl.size(); i++) apply(tbl[i], i + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares one `fifo` instance between `N_REQ` producers. Each producer offers words on a valid/ready handshake. The arbiter selects one producer per cycle by round-robin and registers the selected word into a one-entry output stage, which drives the FIFO's `data_input`/`write_enable_input` and is held off by the FIFO's `full`. It sits directly in front of the shared FIFO in the model datapath.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..16).
- `DATA_WIDTH`, 64: word width; must match the FIFO.
- `ID_WIDTH`, `$clog2(N_REQ)`: requester index width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in `N_REQ`: requester i offers a word.
- `req_data` in `N_REQ x DATA_WIDTH`: word of requester i.
- `req_last` in `N_REQ`: word is the final word of a burst.
- `req_ready` out `N_REQ`: word of requester i accepted this cycle.
- `fifo_data` out `DATA_WIDTH`: to FIFO `data_input`.
- `fifo_write_enable` out 1: to FIFO `write_enable_input`.
- `fifo_full` in 1: from FIFO `full`.
- `grant_id` out `ID_WIDTH`: source index of the word in the output stage.
- `wr_count` out 32: total words written into the FIFO, wraps modulo 2^32.

## Operation
- Output stage: `out_valid`, `out_data`, `out_id` registers.
- `fifo_write_enable = out_valid & ~fifo_full`.
- `fifo_data = out_data`.
- `grant_id = out_id`.
- `can_accept = ~out_valid | ~fifo_full`: the stage is empty, or it drains this cycle.
- Arbitration is combinational each cycle. Among valid requesters, pick the first at or after `rr_ptr`, searching with wrap-around from `N_REQ-1` to 0.
- `req_ready[w] = can_accept & ~rst` for the winner w; all other ready bits are 0.
- A requester with `req_valid=0` never gets ready.
- On accept (`req_valid[w] & req_ready[w]`) at the rising edge:
  - `out_data <= req_data[w]`, `out_id <= w`, `out_valid <= 1`.
  - `rr_ptr <= (w+1) mod N_REQ`.
- If the stage drains with no accept: `out_valid <= 0`, and `out_data`/`out_id` hold.
- If the stage is full and stalled: all registers hold and all ready bits are 0.
- `wr_count` increments on every cycle with `fifo_write_enable=1`.
- State machine: `ARB` and `LOCK`. Without the macro, the state is permanently `ARB`.
- Reset:
  - `out_valid=0`, `out_data=0`, `out_id=0`, `rr_ptr=0`, `wr_count=0`, state `ARB`.
  - Therefore `fifo_write_enable=0`, `fifo_data=0`, `grant_id=0`, `req_ready=0` during reset.
  - Reset mid-transfer discards any held word, and no handshake completes in a reset cycle.

## Timing
- Latency: a word accepted at edge k appears on `fifo_data` with `fifo_write_enable=1` during cycle k+1. It is written into the FIFO at edge k+1 if `fifo_full=0`.
- Throughput is one word per cycle while the FIFO is not full; the stage drains and refills in the same cycle.
- `fifo_full` asserted: the stage holds its word, and `req_ready` stays 0 until the cycle `fifo_full` deasserts.
- The arbiter never writes when full, so the FIFO's internal write gating is never exercised.
- Requester rules:
  - Data and `req_last` must stay stable while valid and not ready.
  - Dropping `req_valid` before ready is allowed; the arbiter simply re-arbitrates.

## Configuration
- `FIFO_ARB_BURST_LOCK_EN` defined:
  - An accept with `req_last=0` moves `ARB`→`LOCK` and records `lock_id=w`.
  - In `LOCK`, only `lock_id` may win; other requesters get no ready even when the stage can accept.
  - `rr_ptr` does not advance in `LOCK`.
  - An accept with `req_last=1` returns the FSM to `ARB` and sets `rr_ptr=lock_id+1`.
  - If `lock_id` drops valid, the lock is kept.
  - Reset clears the lock.
- Undefined:
  - `req_last` is ignored, and grants rotate per word.
  - The port remains present.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum `arb_state_e {ARB, LOCK}`;
  - the 32-bit `wr_count_t` typedef;
  - the `MAX_REQ=16` constant.
- Sub-module `rr_pick`: purely combinational. Inputs are the valid vector and the pointer; outputs are the one-hot grant and its index. It uses the double-width mask-and-priority method.
- The top level holds the output stage, pointer, FSM and counter.

## Test plan
- Single producer: after reset, req0 sends 3 words A,B,C back-to-back with FIFO empty.
  - FIFO writes occur at cycles 1,2,3 after first accept.
  - `grant_id=0`, `wr_count=3`.
- Round-robin: all 4 requesters valid continuously with `fifo_full=0`.
  - Grant order is 0,1,2,3,0,1.
  - No requester is served twice before the others are served once.
- Backpressure: hold `fifo_full=1` for 5 cycles with word X in the stage.
  - X is held, `fifo_write_enable=0`, `req_ready=0`.
  - After release, X is written in the first non-full cycle and the next accept occurs that same cycle.
- Burst lock (macro on): req1 sends 3 words with `req_last` on the third while req0 and req2 are valid.
  - Grants are 1,1,1, then 2.
  - With the macro off, grants are 1,2,0,1.
- Reset mid-operation: assert `rst` one cycle while the stage holds a word and `fifo_full=1`.
  - Next cycle: `fifo_write_enable=0`, `wr_count=0`, `rr_ptr=0`.
  - The held word never reaches the FIFO.
- Drop valid: req2 withdraws valid while stalled.
  - Arbitration moves to the next valid requester, and no word from req2 is written.
